// File: rtl/root_sched.sv
// root_sched: round-robin front end for a shared root engine.
// Accepts one job at a time from up to four requesters, starts the engine,
// waits for its result and returns it with the requester id. Exponent 0 is
// rejected without touching the engine. Tracks engine latency per job.
module root_sched #(
  parameter int NREQ  = 4,
  parameter int LAT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*10-1:0]  req_radicand,
  input  logic [NREQ*3-1:0]   req_exp,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [1:0]          resp_id,
  output logic [19:0]         resp_data,
  output logic                resp_err,
  output logic                eng_in_valid,
  output logic [9:0]          eng_in_data_1,
  output logic [2:0]          eng_in_data_2,
  input  logic                eng_out_valid,
  input  logic [19:0]         eng_out_data,
  output logic [LAT_W-1:0]    last_latency
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       rr_ptr;
  logic [1:0]       job_id;
  logic [9:0]       job_rad;
  logic [2:0]       job_exp;
  logic [19:0]      data_q;
  logic             err_q;
  logic [LAT_W-1:0] lat_cnt;

  // Requester view padded to four slots so the id can index it directly.
  logic [3:0]       vld_pad;
  logic [9:0]       rad_arr [4];
  logic [2:0]       exp_arr [4];
  logic [3:0]       rdy_pad;

  logic             grant_vld;
  logic [1:0]       grant_id;
  logic [1:0]       idx;
  logic             xfer;
  logic             grant_err;

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + {{(LAT_W-1){1'b0}}, 1'b1};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_unpack
    if (g < NREQ) begin : g_act
      assign vld_pad[g] = req_valid[g];
      assign rad_arr[g] = req_radicand[10*g +: 10];
      assign exp_arr[g] = req_exp[3*g +: 3];
    end else begin : g_pad
      assign vld_pad[g] = 1'b0;
      assign rad_arr[g] = '0;
      assign exp_arr[g] = '0;
    end
  end

  // Round-robin search starting at rr_ptr, wrapping at NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = 2'((int'(rr_ptr) + k) % NREQ);
      if (!grant_vld && vld_pad[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  // A grant only happens in IDLE once a lingering engine result has dropped;
  // rst_n gating keeps req_ready low while reset is held.
  assign xfer      = rst_n && (state == IDLE) && grant_vld && !eng_out_valid;
  assign grant_err = (exp_arr[grant_id] == 3'd0);

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt     = state;
    rdy_pad       = '0;
    resp_valid    = 1'b0;
    eng_in_valid  = 1'b0;
    eng_in_data_1 = '0;
    eng_in_data_2 = '0;
    case (state)
      IDLE: begin
        rdy_pad[grant_id] = xfer;
        if (xfer) state_nxt = grant_err ? RESP : ISSUE;
      end
      ISSUE: begin
        eng_in_valid  = 1'b1;
        eng_in_data_1 = job_rad;
        eng_in_data_2 = job_exp;
        state_nxt     = WAIT;
      end
      WAIT: begin
        eng_in_data_1 = job_rad;
        eng_in_data_2 = job_exp;
        if (eng_out_valid) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = rdy_pad[NREQ-1:0];
  assign resp_id   = job_id;
  assign resp_data = data_q;
  assign resp_err  = err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration pointer and job capture on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      job_id  <= '0;
      job_rad <= '0;
      job_exp <= '0;
    end else if (xfer) begin
      rr_ptr  <= 2'((int'(grant_id) + 1) % NREQ);
      job_id  <= grant_id;
      job_rad <= rad_arr[grant_id];
      job_exp <= exp_arr[grant_id];
    end
  end

  // Response payload and engine latency measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      err_q        <= 1'b0;
      lat_cnt      <= '0;
      last_latency <= '0;
    end else begin
      if (xfer) begin
        data_q  <= '0;
        err_q   <= grant_err;
        lat_cnt <= '0;
      end
      if (state == ISSUE || state == WAIT) lat_cnt <= sat_inc(lat_cnt);
      if (state == WAIT && eng_out_valid) begin
        data_q       <= eng_out_data;
        last_latency <= lat_cnt;
      end
    end
  end

endmodule

// File: tb/tb_root_sched.sv
// Scoreboard bench for root_sched with a behavioral root engine.
module tb_root_sched;
  localparam int NREQ  = 4;
  localparam int LAT_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*10-1:0] req_radicand;
  logic [NREQ*3-1:0]  req_exp;
  logic               resp_valid;
  logic               resp_ready;
  logic [1:0]         resp_id;
  logic [19:0]        resp_data;
  logic               resp_err;
  logic               eng_in_valid;
  logic [9:0]         eng_in_data_1;
  logic [2:0]         eng_in_data_2;
  logic               eng_out_valid;
  logic [19:0]        eng_out_data;
  logic [LAT_W-1:0]   last_latency;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  id;
    logic [19:0] data;
    logic        err;
    int          lat;
  } resp_t;
  typedef struct {
    logic [9:0] rad;
    logic [2:0] e;
  } iss_t;

  resp_t resp_q[$];
  iss_t  iss_q[$];

  int eng_lat  = 2;
  int eng_hold = 1;
  int e_cnt;
  int e_hold;
  logic [19:0] e_res;

  root_sched #(.NREQ(NREQ), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_radicand(req_radicand), .req_exp(req_exp),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .eng_in_valid(eng_in_valid), .eng_in_data_1(eng_in_data_1),
    .eng_in_data_2(eng_in_data_2),
    .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data),
    .last_latency(last_latency)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Known root results (Q10.10) for the operands used here.
  function automatic logic [19:0] eng_fn(input logic [9:0] r, input logic [2:0] e);
    if (e == 3'd1) return {r, 10'd0};
    if (e == 3'd2) begin
      case (r)
        10'd4:   return 20'h00800;
        10'd9:   return 20'h00C00;
        10'd16:  return 20'h01000;
        10'd25:  return 20'h01400;
        default: return 20'hFFFFF;
      endcase
    end
    return 20'hFFFFF;
  endfunction

  // Engine: result valid eng_lat cycles after the start pulse, held eng_hold cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_cnt         <= 0;
      e_hold        <= 0;
      e_res         <= '0;
      eng_out_valid <= 1'b0;
      eng_out_data  <= '0;
    end else begin
      if (eng_in_valid) begin
        e_cnt <= eng_lat - 1;
        e_res <= eng_fn(eng_in_data_1, eng_in_data_2);
      end else if (e_cnt > 0) begin
        e_cnt <= e_cnt - 1;
      end
      if (e_cnt == 1) begin
        eng_out_valid <= 1'b1;
        eng_out_data  <= e_res;
        e_hold        <= eng_hold - 1;
      end else if (e_hold > 0) begin
        e_hold <= e_hold - 1;
      end else begin
        eng_out_valid <= 1'b0;
      end
    end
  end

  // Requesters drop valid once their job has been accepted.
  always @(posedge clk) begin : drv
    logic [NREQ-1:0] hs;
    hs = req_valid & req_ready;
    #1;
    req_valid = req_valid & ~hs;
  end

  // Engine start monitor.
  always @(negedge clk) begin
    if (rst_n && eng_in_valid) begin
      if (iss_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL eng_unexpected: start with %0d/%0d, none expected", eng_in_data_1, eng_in_data_2);
      end else begin
        iss_t ie;
        ie = iss_q.pop_front();
        check("eng_in_data_1", 32'(eng_in_data_1), 32'(ie.rad));
        check("eng_in_data_2", 32'(eng_in_data_2), 32'(ie.e));
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected: id=%0d data=%0h err=%0d", resp_id, resp_data, resp_err);
      end else begin
        resp_t re;
        re = resp_q.pop_front();
        check("resp_id", 32'(resp_id), 32'(re.id));
        check("resp_data", 32'(resp_data), 32'(re.data));
        check("resp_err", 32'(resp_err), 32'(re.err));
        if (re.lat >= 0) check("last_latency", 32'(last_latency), 32'(re.lat));
      end
    end
  end

  task automatic exp_resp(input logic [1:0] id, input logic [19:0] d, input logic er, input int lat);
    resp_t r;
    r.id = id; r.data = d; r.err = er; r.lat = lat;
    resp_q.push_back(r);
  endtask

  task automatic exp_iss(input logic [9:0] rad, input logic [2:0] e);
    iss_t s;
    s.rad = rad; s.e = e;
    iss_q.push_back(s);
  endtask

  task automatic send(input int i, input logic [9:0] rad, input logic [2:0] e);
    req_radicand[10*i +: 10] = rad;
    req_exp[3*i +: 3]        = e;
    req_valid[i]             = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((resp_q.size() != 0 || iss_q.size() != 0 || req_valid != '0 || resp_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: timeout, pending resp=%0d iss=%0d", name, resp_q.size(), iss_q.size());
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_resp_valid"}, 32'(resp_valid), 0);
    check({name, "_req_ready"}, 32'(req_ready), 0);
    check({name, "_eng_in_valid"}, 32'(eng_in_valid), 0);
    check({name, "_eng_in_data_1"}, 32'(eng_in_data_1), 0);
    check({name, "_eng_in_data_2"}, 32'(eng_in_data_2), 0);
    check({name, "_resp_id"}, 32'(resp_id), 0);
    check({name, "_resp_data"}, 32'(resp_data), 0);
    check({name, "_resp_err"}, 32'(resp_err), 0);
    check({name, "_last_latency"}, 32'(last_latency), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [23:0] snap;
    int n;
    req_valid    = '0;
    req_radicand = '0;
    req_exp      = '0;
    resp_ready   = 1'b1;
    #1 rst_n = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clk);
    #1 check_outputs_zero("reset");
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin from reset: 0,1,2,3, then re-asserted 0 after 3.
    eng_lat = 2; eng_hold = 1;
    send(0, 10'd1, 3'd1); send(1, 10'd2, 3'd1); send(2, 10'd3, 3'd1); send(3, 10'd4, 3'd1);
    exp_iss(10'd1, 3'd1); exp_iss(10'd2, 3'd1); exp_iss(10'd3, 3'd1); exp_iss(10'd4, 3'd1);
    exp_iss(10'd7, 3'd1);
    exp_resp(2'd0, 20'h00400, 1'b0, 2); exp_resp(2'd1, 20'h00800, 1'b0, 2);
    exp_resp(2'd2, 20'h00C00, 1'b0, 2); exp_resp(2'd3, 20'h01000, 1'b0, 2);
    exp_resp(2'd0, 20'h01C00, 1'b0, 2);
    n = 0;
    while (req_valid[0] && n < 50) begin @(negedge clk); n++; end
    check("rr_first_grant", 32'(req_valid[0]), 0);
    send(0, 10'd7, 3'd1);
    drain("rr", 200);

    // Square root of 16 from requester 0.
    eng_lat = 3;
    exp_iss(10'd16, 3'd2); exp_resp(2'd0, 20'h01000, 1'b0, 3);
    send(0, 10'd16, 3'd2);
    drain("sqrt16", 100);

    // Identity root of 5 from requester 2, longer engine latency.
    eng_lat = 5;
    exp_iss(10'd5, 3'd1); exp_resp(2'd2, 20'h01400, 1'b0, 5);
    send(2, 10'd5, 3'd1);
    drain("root5", 100);

    // Exponent 0: rejected, engine untouched, last_latency unchanged.
    exp_resp(2'd1, 20'h00000, 1'b1, 5);
    send(1, 10'd33, 3'd0);
    drain("exp0", 100);

    // Backpressure in RESP with a two-cycle engine result.
    resp_ready = 1'b0; eng_lat = 3; eng_hold = 2;
    exp_iss(10'd9, 3'd2); exp_resp(2'd3, 20'h00C00, 1'b0, 3);
    send(3, 10'd9, 3'd2);
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_resp_seen", 32'(resp_valid), 1);
    snap = {1'b1, resp_id, resp_data, resp_err};
    exp_iss(10'd8, 3'd1); exp_resp(2'd0, 20'h02000, 1'b0, 3);
    send(0, 10'd8, 3'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold", 32'({resp_valid, resp_id, resp_data, resp_err}), 32'(snap));
      check("bp_no_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    drain("backpressure", 100);

    // Latency counter saturates.
    eng_lat = 300; eng_hold = 1;
    exp_iss(10'd1, 3'd1); exp_resp(2'd2, 20'h00400, 1'b0, 255);
    send(2, 10'd1, 3'd1);
    drain("saturate", 400);

    // Reset while waiting on the engine: job abandoned, pointer cleared.
    eng_lat = 10;
    exp_iss(10'd4, 3'd2);
    send(2, 10'd4, 3'd2);
    n = 0;
    while (!eng_in_valid && n < 50) begin @(negedge clk); n++; end
    check("rst_issue_seen", 32'(eng_in_valid), 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("rst_wait");
    eng_lat = 3;
    exp_iss(10'd25, 3'd2); exp_iss(10'd16, 3'd2);
    exp_resp(2'd1, 20'h01400, 1'b0, 3); exp_resp(2'd3, 20'h01000, 1'b0, 3);
    send(1, 10'd25, 3'd2); send(3, 10'd16, 3'd2);
    @(negedge clk);
    check("rst_held_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    #1 check("rst_first_grant", 32'(req_ready), 32'(4'b0010));
    drain("after_reset", 100);

    check("final_resp_q_empty", 32'(resp_q.size()), 0);
    check("final_iss_q_empty", 32'(iss_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
